ysyx_22040750_trap_ctrl: RTL and testbench
==========================================

// Module: ysyx_22040750_trap_ctrl
// PURPOSE
// - Trap sequencer for the machine-mode CSR file: detects ecall, mret and timer interrupt at the WB boundary.
// - Drives the CSR trap/return strobes and cause/PC values, flushes the pipeline, and redirects IF to mtvec or mepc.
// - Sits between the WB stage, the CLINT timer line and the CSR file. It is the only source of the CSR intr/mret strobes.
// PARAMETERS
// - PC_W        32                      instruction address width
// - XLEN        64                      CSR data width
// - IRQ_CAUSE   64'h8000_0000_0000_0007 mcause value for the machine timer interrupt
// - ECALL_CAUSE 64'd11                  mcause value for ecall from M-mode
// PORTS
// - I_sys_clk        in   1     clock
// - I_rst            in   1     synchronous reset, active-high
// - I_MEM_WB_valid   in   1     WB stage holds a valid instruction
// - I_WB_pc          in   PC_W  PC of the WB instruction
// - I_WB_ecall       in   1     WB instruction is ecall
// - I_WB_mret        in   1     WB instruction is mret
// - I_timer_irq      in   1     CLINT mtip level
// - I_mstatus_mie    in   1     mstatus.MIE from the CSR file
// - I_mie_mtie       in   1     mie.MTIE from the CSR file
// - I_csr_rd_data    in   XLEN  CSR read data (mtvec or mepc while the rd strobes are high)
// - O_csr_intr_wr    out  1     CSR trap-entry update strobe
// - O_csr_intr_rd    out  1     select mtvec on the CSR read port
// - O_csr_mret_wr    out  1     CSR mret update strobe
// - O_csr_mret_rd    out  1     select mepc on the CSR read port
// - O_csr_intr_no    out  XLEN  cause value for mcause
// - O_intr_pc        out  PC_W  value for mepc
// - O_wb_kill        out  1     suppress GPR/CSR writeback of the WB instruction (interrupt only)
// - O_flush          out  1     flush IF..MEM
// - O_redirect_valid out  1     redirect request to IF
// - O_redirect_pc    out  PC_W  redirect target
// - I_redirect_ready in   1     IF accepts the redirect this cycle
// BEHAVIOUR
// - States: IDLE, REDIR. Reset (sync, any state): state=IDLE; all outputs 0; target reg 0.
// - Event qualification in IDLE only, and only when I_MEM_WB_valid=1:
//   irq   = I_timer_irq & I_mstatus_mie & I_mie_mtie
//   trap  = irq | I_WB_ecall
//   ret   = ~irq & I_WB_mret
// - Priority: irq > ecall > mret. An interrupt preempts an ecall/mret in WB, so that instruction does not execute.
// - Trap cycle (comb, same cycle as the event):
//   - O_csr_intr_rd=1, O_csr_intr_wr=1, O_flush=1.
//   - O_csr_intr_no = irq ? IRQ_CAUSE : ECALL_CAUSE.
//   - O_intr_pc = I_WB_pc. O_wb_kill = irq.
//   - Target reg <= {I_csr_rd_data[PC_W-1:2],2'b00} (mtvec direct mode). State <= REDIR.
// - Ret cycle (comb): O_csr_mret_rd=1, O_csr_mret_wr=1, O_flush=1. Target <= I_csr_rd_data[PC_W-1:0]. State <= REDIR.
// - All strobes are 1-cycle pulses, mutually exclusive, and asserted only while I_MEM_WB_valid=1.
// - REDIR: O_redirect_valid=1, O_redirect_pc=target, O_flush=1 (held). Target and outputs stay stable until I_redirect_ready.
//   - On ready: state <= IDLE. Earliest next trap is the following cycle.
// - In REDIR, all WB inputs and I_timer_irq are ignored. Assertion: I_MEM_WB_valid=0 in REDIR.
// - A timer level still pending on return to IDLE traps only if MIE is set; trap entry clears MIE, so there is no re-entry storm.
// - Latency: event-to-redirect = 1 cycle minimum; CSR state is updated at the event-cycle edge.
// - ecall and mret both set in WB is illegal; if it occurs, ecall wins.
// STRUCTURE
// - Shared package: CSR addresses (MSTATUS 12'h300, MIE 12'h304, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342), cause constants, state encoding.
// - One optional sub-module: ysyx_22040750_trap_prio (combinational irq/ecall/mret priority encoder). FSM and target reg stay in this module.
// TESTING
// - Ecall: WB valid, ecall, pc=0x8000_0100, mtvec=0x8000_0004 -> intr_wr pulse, intr_no=11, intr_pc=0x8000_0100; next cycle redirect_pc=0x8000_0004.
// - Mret: mepc=0x8000_0104, WB mret -> mret_wr/mret_rd pulse, redirect_pc=0x8000_0104; mstatus.MIE restored from MPIE.
// - Irq vs ecall: timer_irq=1, MIE=1, MTIE=1, WB ecall -> intr_no=0x8000_0000_0000_0007, wb_kill=1, mepc=ecall pc.
// - Masked irq: timer_irq=1, MIE=0 -> no strobes. Set MIE=1 -> trap on the next valid WB.
// - Backpressure: hold redirect_ready=0 for 5 cycles -> redirect_valid, pc and flush stable; no further strobes; IDLE one cycle after ready.
// - Reset mid-REDIR: I_rst=1 for 1 cycle -> next cycle all outputs 0, state IDLE, no redirect.

Source files
------------

// File: rtl/ysyx_22040750_trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses,
// mcause values and the sequencer state encoding.
package ysyx_22040750_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] CAUSE_M_TIMER_IRQ = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL_M     = 64'd11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } trap_state_e;

endpackage

// File: rtl/ysyx_22040750_trap_prio.sv
// Combinational event priority: timer interrupt > ecall > mret.
// All outputs are zero unless the sequencer can accept an event this cycle.
module ysyx_22040750_trap_prio (
    input  logic I_en,
    input  logic I_timer_irq,
    input  logic I_mstatus_mie,
    input  logic I_mie_mtie,
    input  logic I_ecall,
    input  logic I_mret,
    output logic O_irq,
    output logic O_trap,
    output logic O_ret
);

    always_comb begin
        O_irq  = I_en & I_timer_irq & I_mstatus_mie & I_mie_mtie;
        O_trap = O_irq | (I_en & I_ecall);
        // An ecall sharing WB with an mret wins, keeping the strobes exclusive.
        O_ret  = I_en & ~O_irq & ~I_ecall & I_mret;
    end

endmodule

// File: rtl/ysyx_22040750_trap_ctrl.sv
// Trap sequencer at the WB boundary: raises CSR trap/return strobes in the event
// cycle, then holds a flush plus IF redirect to mtvec/mepc until IF accepts it.
module ysyx_22040750_trap_ctrl
    import ysyx_22040750_trap_ctrl_pkg::*;
#(
    parameter int          PC_W        = 32,
    parameter int          XLEN        = 64,
    parameter logic [63:0] IRQ_CAUSE   = CAUSE_M_TIMER_IRQ,
    parameter logic [63:0] ECALL_CAUSE = CAUSE_ECALL_M
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_MEM_WB_valid,
    input  logic [PC_W-1:0] I_WB_pc,
    input  logic            I_WB_ecall,
    input  logic            I_WB_mret,
    input  logic            I_timer_irq,
    input  logic            I_mstatus_mie,
    input  logic            I_mie_mtie,
    input  logic [XLEN-1:0] I_csr_rd_data,
    output logic            O_csr_intr_wr,
    output logic            O_csr_intr_rd,
    output logic            O_csr_mret_wr,
    output logic            O_csr_mret_rd,
    output logic [XLEN-1:0] O_csr_intr_no,
    output logic [PC_W-1:0] O_intr_pc,
    output logic            O_wb_kill,
    output logic            O_flush,
    output logic            O_redirect_valid,
    output logic [PC_W-1:0] O_redirect_pc,
    input  logic            I_redirect_ready
);

    trap_state_e     state_q;
    logic [PC_W-1:0] target_q;
    logic            accept;
    logic            irq;
    logic            trap;
    logic            ret;
    logic            in_redir;
    logic            unused_rd_bits;

    assign unused_rd_bits = ^{I_csr_rd_data[XLEN-1:PC_W], I_csr_rd_data[1:0]};

    // Reset forces every output low in the same cycle, including the strobes.
    assign accept   = (state_q == ST_IDLE) & ~I_rst & I_MEM_WB_valid;
    assign in_redir = (state_q == ST_REDIR) & ~I_rst;

    ysyx_22040750_trap_prio u_prio (
        .I_en          (accept),
        .I_timer_irq   (I_timer_irq),
        .I_mstatus_mie (I_mstatus_mie),
        .I_mie_mtie    (I_mie_mtie),
        .I_ecall       (I_WB_ecall),
        .I_mret        (I_WB_mret),
        .O_irq         (irq),
        .O_trap        (trap),
        .O_ret         (ret)
    );

    always_comb begin
        O_csr_intr_wr    = trap;
        O_csr_intr_rd    = trap;
        O_csr_mret_wr    = ret;
        O_csr_mret_rd    = ret;
        O_csr_intr_no    = '0;
        O_intr_pc        = '0;
        O_wb_kill        = irq;
        O_flush          = trap | ret | in_redir;
        O_redirect_valid = in_redir;
        O_redirect_pc    = in_redir ? target_q : '0;
        if (trap) begin
            O_csr_intr_no = irq ? IRQ_CAUSE[XLEN-1:0] : ECALL_CAUSE[XLEN-1:0];
            O_intr_pc     = I_WB_pc;
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // mtvec is used in direct mode, so its mode bits are dropped.
                    if (trap) begin
                        target_q <= {I_csr_rd_data[PC_W-1:2], 2'b00};
                        state_q  <= ST_REDIR;
                    end else if (ret) begin
                        target_q <= I_csr_rd_data[PC_W-1:0];
                        state_q  <= ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    if (I_redirect_ready) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The pipeline is being flushed while redirecting, so WB must be empty.
    a_no_wb_in_redir : assert property (@(posedge I_sys_clk) disable iff (I_rst)
        (state_q == ST_REDIR) |-> !I_MEM_WB_valid);

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// Directed bench for the trap sequencer: ecall, mret, irq preemption, masking,
// redirect backpressure and reset during a redirect.
module tb_ysyx_22040750_trap_ctrl;

    localparam logic [63:0] IRQ_NO   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] ECALL_NO = 64'd11;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_ecall;
    logic        wb_mret;
    logic        timer_irq;
    logic        mstatus_mie;
    logic        mie_mtie;
    logic [63:0] csr_rd_data;
    logic        csr_intr_wr;
    logic        csr_intr_rd;
    logic        csr_mret_wr;
    logic        csr_mret_rd;
    logic [63:0] csr_intr_no;
    logic [31:0] intr_pc;
    logic        wb_kill;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int n_vec;
    int n_miss;

    ysyx_22040750_trap_ctrl dut (
        .I_sys_clk        (clk),
        .I_rst            (rst),
        .I_MEM_WB_valid   (wb_valid),
        .I_WB_pc          (wb_pc),
        .I_WB_ecall       (wb_ecall),
        .I_WB_mret        (wb_mret),
        .I_timer_irq      (timer_irq),
        .I_mstatus_mie    (mstatus_mie),
        .I_mie_mtie       (mie_mtie),
        .I_csr_rd_data    (csr_rd_data),
        .O_csr_intr_wr    (csr_intr_wr),
        .O_csr_intr_rd    (csr_intr_rd),
        .O_csr_mret_wr    (csr_mret_wr),
        .O_csr_mret_rd    (csr_mret_rd),
        .O_csr_intr_no    (csr_intr_no),
        .O_intr_pc        (intr_pc),
        .O_wb_kill        (wb_kill),
        .O_flush          (flush),
        .O_redirect_valid (redirect_valid),
        .O_redirect_pc    (redirect_pc),
        .I_redirect_ready (redirect_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Samples all outputs at the falling edge of the current cycle.
    task automatic check_outs(input string tag,
                              input logic iw, input logic ir, input logic mw, input logic mr,
                              input logic [63:0] no, input logic [31:0] ipc, input logic kill,
                              input logic fl, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        check_val({tag, ".intr_wr"}, 64'(csr_intr_wr), 64'(iw));
        check_val({tag, ".intr_rd"}, 64'(csr_intr_rd), 64'(ir));
        check_val({tag, ".mret_wr"}, 64'(csr_mret_wr), 64'(mw));
        check_val({tag, ".mret_rd"}, 64'(csr_mret_rd), 64'(mr));
        check_val({tag, ".intr_no"}, csr_intr_no, no);
        check_val({tag, ".intr_pc"}, 64'(intr_pc), 64'(ipc));
        check_val({tag, ".wb_kill"}, 64'(wb_kill), 64'(kill));
        check_val({tag, ".flush"}, 64'(flush), 64'(fl));
        check_val({tag, ".rdir_v"}, 64'(redirect_valid), 64'(rv));
        check_val({tag, ".rdir_pc"}, 64'(redirect_pc), 64'(rpc));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // driver: WB instruction slot
    task automatic drive_wb(input logic v, input logic [31:0] pc, input logic ec,
                            input logic mr, input logic [63:0] rd);
        wb_valid    = v;
        wb_pc       = pc;
        wb_ecall    = ec;
        wb_mret     = mr;
        csr_rd_data = rd;
    endtask

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        rst            = 1'b1;
        timer_irq      = 1'b0;
        mstatus_mie    = 1'b0;
        mie_mtie       = 1'b0;
        redirect_ready = 1'b0;
        drive_wb(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        next_cycle();
        next_cycle();
        check_outs("reset", 0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 0, 32'h0);
        next_cycle();
        rst = 1'b0;

        // ecall trap, then redirect to mtvec
        drive_wb(1'b1, 32'h8000_0100, 1'b1, 1'b0, 64'h8000_0004);
        check_outs("ecall", 1, 1, 0, 0, ECALL_NO, 32'h8000_0100, 0, 1, 0, 32'h0);
        next_cycle();
        drive_wb(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        redirect_ready = 1'b1;
        check_outs("ecall_rdir", 0, 0, 0, 0, 64'h0, 32'h0, 0, 1, 1, 32'h8000_0004);
        next_cycle();
        redirect_ready = 1'b0;
        check_outs("ecall_idle", 0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 0, 32'h0);
        next_cycle();

        // mret, then redirect to mepc
        drive_wb(1'b1, 32'h8000_0008, 1'b0, 1'b1, 64'h8000_0104);
        check_outs("mret", 0, 0, 1, 1, 64'h0, 32'h0, 0, 1, 0, 32'h0);
        next_cycle();
        drive_wb(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        redirect_ready = 1'b1;
        check_outs("mret_rdir", 0, 0, 0, 0, 64'h0, 32'h0, 0, 1, 1, 32'h8000_0104);
        next_cycle();
        redirect_ready = 1'b0;
        mstatus_mie    = 1'b1;
        mie_mtie       = 1'b1;

        // timer irq preempts an ecall in WB; mtvec mode bits dropped
        timer_irq = 1'b1;
        drive_wb(1'b1, 32'h8000_0200, 1'b1, 1'b0, 64'h8000_1003);
        check_outs("irq_ecall", 1, 1, 0, 0, IRQ_NO, 32'h8000_0200, 1, 1, 0, 32'h0);
        next_cycle();
        mstatus_mie = 1'b0;
        drive_wb(1'b0, 32'h8000_0204, 1'b1, 1'b1, 64'hdead_beef);

        // backpressure: redirect held stable, no new strobes
        for (int i = 0; i < 5; i++) begin
            check_outs($sformatf("bp%0d", i), 0, 0, 0, 0, 64'h0, 32'h0, 0, 1, 1, 32'h8000_1000);
            next_cycle();
        end
        redirect_ready = 1'b1;
        check_outs("bp_accept", 0, 0, 0, 0, 64'h0, 32'h0, 0, 1, 1, 32'h8000_1000);
        next_cycle();
        redirect_ready = 1'b0;

        // pending timer with MIE cleared: plain instruction retires normally
        drive_wb(1'b1, 32'h8000_1000, 1'b0, 1'b0, 64'h0);
        check_outs("masked_irq", 0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 0, 32'h0);
        next_cycle();
        mstatus_mie = 1'b1;
        drive_wb(1'b0, 32'h8000_1004, 1'b0, 1'b0, 64'h0);
        check_outs("irq_no_valid", 0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 0, 32'h0);
        next_cycle();
        drive_wb(1'b1, 32'h8000_1004, 1'b0, 1'b0, 64'h8000_2000);
        check_outs("unmasked_irq", 1, 1, 0, 0, IRQ_NO, 32'h8000_1004, 1, 1, 0, 32'h0);
        next_cycle();
        drive_wb(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        redirect_ready = 1'b1;
        check_outs("irq_rdir", 0, 0, 0, 0, 64'h0, 32'h0, 0, 1, 1, 32'h8000_2000);
        next_cycle();
        redirect_ready = 1'b0;
        timer_irq      = 1'b0;

        // ecall and mret together: ecall wins; then reset mid-redirect
        drive_wb(1'b1, 32'h8000_0300, 1'b1, 1'b1, 64'h8000_0040);
        check_outs("ecall_mret", 1, 1, 0, 0, ECALL_NO, 32'h8000_0300, 0, 1, 0, 32'h0);
        next_cycle();
        drive_wb(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        check_outs("pre_rst_rdir", 0, 0, 0, 0, 64'h0, 32'h0, 0, 1, 1, 32'h8000_0040);
        next_cycle();
        rst = 1'b1;
        check_outs("rst_in_redir", 0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 0, 32'h0);
        next_cycle();
        rst = 1'b0;
        check_outs("after_rst", 0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 0, 32'h0);
        next_cycle();

        // ecall on an invalid WB slot is ignored
        drive_wb(1'b0, 32'h8000_0400, 1'b1, 1'b0, 64'h8000_0004);
        check_outs("ecall_invalid", 0, 0, 0, 0, 64'h0, 32'h0, 0, 0, 0, 32'h0);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
